// File: rtl/iir_coeff_loader_if.sv
// Coefficient-loader bus: GPIO writes and sample strobe in, active biquad coefficient set and status out.
// IIR_COEFF_READBACK_EN adds rd_data to the bus.
interface iir_coeff_loader_if #(
    parameter int COEFF_WIDTH = 32
);
    logic        [COEFF_WIDTH-1:0] cfg_data;
    logic        [2:0]             cfg_addr;
    logic                          cfg_wr;
    logic                          sample_tick;
    logic signed [COEFF_WIDTH-1:0] b0, b1, b2, a1, a2, gain;
    logic                          coeff_update;
    logic                          busy;
    logic                          err_sticky;
    logic                          timeout_sticky;
`ifdef IIR_COEFF_READBACK_EN
    logic        [COEFF_WIDTH-1:0] rd_data;

    modport master (
        output cfg_data, cfg_addr, cfg_wr, sample_tick,
        input  b0, b1, b2, a1, a2, gain, coeff_update, busy, err_sticky, timeout_sticky, rd_data
    );
    modport slave (
        input  cfg_data, cfg_addr, cfg_wr, sample_tick,
        output b0, b1, b2, a1, a2, gain, coeff_update, busy, err_sticky, timeout_sticky, rd_data
    );
`else
    modport master (
        output cfg_data, cfg_addr, cfg_wr, sample_tick,
        input  b0, b1, b2, a1, a2, gain, coeff_update, busy, err_sticky, timeout_sticky
    );
    modport slave (
        input  cfg_data, cfg_addr, cfg_wr, sample_tick,
        output b0, b1, b2, a1, a2, gain, coeff_update, busy, err_sticky, timeout_sticky
    );
`endif
endinterface

// File: rtl/iir_coeff_loader.sv
// Shadows GPIO coefficient writes and commits all six words atomically on a sample tick (or timeout).
// Optional feature macro: IIR_COEFF_READBACK_EN (registered rd_data readback of shadow/status).
module iir_coeff_loader #(
    parameter int                     COEFF_WIDTH    = 32,
    parameter int                     TIMEOUT_CYCLES = 1024,
    parameter logic [COEFF_WIDTH-1:0] RESET_B0       = 32'h4000_0000,
    parameter logic [COEFF_WIDTH-1:0] RESET_GAIN     = 32'h0001_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    iir_coeff_loader_if.slave bus
);
    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    localparam logic [0:0] S_IDLE    = 1'b0;
    localparam logic [0:0] S_PENDING = 1'b1;

    localparam logic [2:0] A_COMMIT = 3'd6;
    localparam logic [2:0] A_CLEAR  = 3'd7;

    // Word order: [0]=b0 [1]=b1 [2]=b2 [3]=a1 [4]=a2 [5]=gain
    localparam logic [5:0][COEFF_WIDTH-1:0] RESET_SET =
        {RESET_GAIN, {(4*COEFF_WIDTH){1'b0}}, RESET_B0};

    logic [5:0][COEFF_WIDTH-1:0] r_shadow;
    logic [5:0][COEFF_WIDTH-1:0] r_active;
    logic [0:0]                  r_state;
    logic [CW-1:0]               r_cnt;
    logic                        r_wr_q;
    logic                        r_update;
    logic                        r_err;
    logic                        r_timeout;

    logic w_wr_pulse;
    logic w_pending;
    logic w_coeff_wr;
    logic w_cnt_last;
    logic w_apply;

    assign w_wr_pulse = bus.cfg_wr & ~r_wr_q;
    assign w_pending  = (r_state == S_PENDING);
    assign w_coeff_wr = w_wr_pulse && (bus.cfg_addr <= 3'd5);
    assign w_cnt_last = (r_cnt == CNT_LAST);
    assign w_apply    = w_pending && (bus.sample_tick || w_cnt_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_wr_q <= 1'b0;
        else        r_wr_q <= bus.cfg_wr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow <= RESET_SET;
        end else if (w_coeff_wr && !w_pending) begin
            for (int i = 0; i < 6; i++) begin
                if (bus.cfg_addr == 3'(i)) r_shadow[i] <= bus.cfg_data;
            end
        end
    end

    // A commit seen in IDLE only arms the FSM; any tick in that same cycle is too early to apply.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_active <= RESET_SET;
            r_update <= 1'b0;
        end else begin
            r_update <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_wr_pulse && bus.cfg_addr == A_COMMIT) begin
                        r_state <= S_PENDING;
                        r_cnt   <= '0;
                    end
                end
                S_PENDING: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (w_apply) begin
                        r_active <= r_shadow;
                        r_update <= 1'b1;
                        r_state  <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err     <= 1'b0;
            r_timeout <= 1'b0;
        end else if (w_wr_pulse && bus.cfg_addr == A_CLEAR) begin
            r_err     <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            if (w_coeff_wr && w_pending)                        r_err     <= 1'b1;
            if (w_pending && !bus.sample_tick && w_cnt_last)    r_timeout <= 1'b1;
        end
    end

`ifdef IIR_COEFF_READBACK_EN
    logic [COEFF_WIDTH-1:0] r_rd_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= '0;
            if (bus.cfg_addr <= 3'd5) begin
                for (int i = 0; i < 6; i++) begin
                    if (bus.cfg_addr == 3'(i)) r_rd_data <= r_shadow[i];
                end
            end else if (bus.cfg_addr == A_COMMIT) begin
                r_rd_data[2:0] <= {r_timeout, r_err, w_pending};
            end
        end
    end

    assign bus.rd_data = r_rd_data;
`endif

    assign bus.b0             = r_active[0];
    assign bus.b1             = r_active[1];
    assign bus.b2             = r_active[2];
    assign bus.a1             = r_active[3];
    assign bus.a2             = r_active[4];
    assign bus.gain           = r_active[5];
    assign bus.coeff_update   = r_update;
    assign bus.busy           = w_pending;
    assign bus.err_sticky     = r_err;
    assign bus.timeout_sticky = r_timeout;
endmodule
